y_arith: RTL and testbench

- Registered 32-bit two's-complement adder/subtractor built as a ripple-carry chain of 1-bit full adders.
- ctrl=0 computes a+b; ctrl=1 computes a-b as a + ~b + 1.
- Sits in the datapath ALU slice.
- Sum, carry-out and status flags are captured in output registers one clock after the operands are presented.

---
 rtl/y_arith.sv | 85 ++++++++
 tb/tb_y_arith.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/y_arith.sv
// Registered WIDTH-bit add/subtract built from a ripple chain of full-adder cells.
// Sum, carry-out, signed overflow and zero flag are captured one clock after the operands.

module y_arith_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module y_arith #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_c;
  logic             w_ovf;
  logic             w_zero;

  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_valid;

  // Subtract is a + ~b + 1: invert b and feed ctrl in as the carry-in.
  assign w_bb   = b ^ {WIDTH{ctrl}};
  assign w_c[0] = ctrl;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    y_arith_fa u_fa (
      .i_a (a[gi]),
      .i_b (w_bb[gi]),
      .i_c (w_c[gi]),
      .o_s (w_s[gi]),
      .o_c (w_c[gi+1])
    );
  end

  assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];
  assign w_zero = (w_s == '0);

  // Result registers update only on valid operands; out_valid pulses per result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_z    <= w_s;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign z         = r_z;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_y_arith.sv
// Self-checking bench for y_arith: directed corner cases, hold, async reset and
// randomized traffic compared against an arithmetic reference model.

module tb_y_arith;

  localparam int unsigned W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          ctrl;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  z;
  logic          cout;
  logic          ovf;
  logic          zero;
  logic          out_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  y_arith #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .z         (z),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  // Reference: 33-bit unsigned sum for z/cout, wide signed arithmetic for overflow.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                                output logic [31:0] ez, output logic ec, output logic eo,
                                output logic ezr);
    logic [31:0] bb;
    logic [32:0] s;
    longint      r;
    bb  = mc ? ~mb : mb;
    s   = {1'b0, ma} + {1'b0, bb} + {32'b0, mc};
    r   = mc ? (longint'($signed(ma)) - longint'($signed(mb)))
             : (longint'($signed(ma)) + longint'($signed(mb)));
    ez  = s[31:0];
    ec  = s[32];
    eo  = (r > SMAX) || (r < SMIN);
    ezr = (s[31:0] == 32'h0);
  endfunction

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb2, input logic tc,
                       input logic tv);
    @(negedge clk);
    a = ta; b = tb2; ctrl = tc; in_valid = tv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; ctrl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({z, cout, ovf, zero, out_valid} !== '0) begin
      bad++;
      $display("FAIL reset_state z=%h cout=%b ovf=%b zero=%b ov=%b required all 0",
               z, cout, ovf, zero, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic        vc [7];
    logic [31:0] ez;
    logic ec, eo, ezr;
    va = '{32'hFFFF_FFFF, 32'd5, 32'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h8000_0000};
    vb = '{32'h0000_0001, 32'd3, 32'd5, 32'h0000_0001, 32'h0000_0001, 32'd0, 32'h8000_0000};
    vc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vb[i], vc[i], 1'b1);
      model(va[i], vb[i], vc[i], ez, ec, eo, ezr);
      total++;
      if (z !== ez || cout !== ec || ovf !== eo || zero !== ezr || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL directed_%0d a=%h b=%h ctrl=%b got z=%h c=%b o=%b zr=%b v=%b want z=%h c=%b o=%b zr=%b v=1",
                 i, va[i], vb[i], vc[i], z, cout, ovf, zero, out_valid, ez, ec, eo, ezr);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] ez;
    logic ec, eo, ezr;
    drive(32'h1234_5678, 32'h0000_0001, 1'b1, 1'b1);
    model(32'h1234_5678, 32'h0000_0001, 1'b1, ez, ec, eo, ezr);
    total++;
    if (z !== ez || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_load got z=%h v=%b want z=%h v=1", z, out_valid, ez);
    end
    for (int i = 0; i < 2; i++) begin
      drive(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
      total++;
      if (z !== ez || cout !== ec || ovf !== eo || zero !== ezr || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold_idle_%0d got z=%h c=%b o=%b zr=%b v=%b want z=%h c=%b o=%b zr=%b v=0",
                 i, z, cout, ovf, zero, out_valid, ez, ec, eo, ezr);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    total++;
    if (z !== 32'h8000_0000 || ovf !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre got z=%h o=%b v=%b want z=80000000 o=1 v=1", z, ovf, out_valid);
    end
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h1; ctrl = 1'b0; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({z, cout, ovf, zero, out_valid} !== '0) begin
      bad++;
      $display("FAIL areset_immediate z=%h c=%b o=%b zr=%b v=%b required all 0",
               z, cout, ovf, zero, out_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if ({z, cout, ovf, zero, out_valid} !== '0) begin
      bad++;
      $display("FAIL areset_discard z=%h c=%b o=%b zr=%b v=%b required all 0",
               z, cout, ovf, zero, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra, rb, ez;
    logic rc, ec, eo, ezr;
    int errs;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        2: rb = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      drive(ra, rb, rc, 1'b1);
      model(ra, rb, rc, ez, ec, eo, ezr);
      total++;
      if (z !== ez || cout !== ec || ovf !== eo || zero !== ezr || out_valid !== 1'b1) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d a=%h b=%h ctrl=%b got z=%h c=%b o=%b zr=%b v=%b want z=%h c=%b o=%b zr=%b v=1",
                   i, ra, rb, rc, z, cout, ovf, zero, out_valid, ez, ec, eo, ezr);
      end
    end
  endtask

  task automatic test_mixed_valid();
    logic [31:0] ra, rb, ez, tz;
    logic rc, rv, ec, eo, ezr, tc, to, tzr;
    int errs;
    errs = 0;
    ez = z; ec = cout; eo = ovf; ezr = zero;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      drive(ra, rb, rc, rv);
      if (rv) begin
        model(ra, rb, rc, tz, tc, to, tzr);
        ez = tz; ec = tc; eo = to; ezr = tzr;
      end
      total++;
      if (z !== ez || cout !== ec || ovf !== eo || zero !== ezr || out_valid !== rv) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL mixed_%0d a=%h b=%h ctrl=%b iv=%b got z=%h c=%b o=%b zr=%b v=%b want z=%h c=%b o=%b zr=%b v=%b",
                   i, ra, rb, rc, rv, z, cout, ovf, zero, out_valid, ez, ec, eo, ezr, rv);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ctrl = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_mixed_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
